// File: rtl/pwm_scan_seq_pkg.sv
// Shared scan-scheduler definitions: state encoding, default geometry and blank length.
// Optional macro PLANE_BLANK_EN stretches the inter-plane BLANK state to BLANK_CYC clocks.
package pwm_scan_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BLANK = 3'd1,
    ST_PSR   = 3'd2,
    ST_LOAD  = 3'd3,
    ST_LATCH = 3'd4,
    ST_ON    = 3'd5
  } scan_state_t;

  localparam int DEF_NPLANES   = 5;
  localparam int DEF_NLEVELS   = 64;
  localparam int DEF_DWELL     = 32;
  localparam int DEF_PSR_HALF  = 2;
  localparam int DEF_BLANK_CYC = 8;

`ifdef PLANE_BLANK_EN
  localparam bit PLANE_BLANK_ON = 1'b1;
`else
  localparam bit PLANE_BLANK_ON = 1'b0;
`endif

  // Clocks spent in BLANK: anti-ghosting dead time when enabled, otherwise a single clock.
  function automatic int blank_len(input int blank_cyc);
    return PLANE_BLANK_ON ? blank_cyc : 1;
  endfunction

endpackage

// File: rtl/pwm_scan_seq_psr_drive.sv
// Plane shift-register driver: one psr_c cycle (PSR_HALF high, PSR_HALF low) per start pulse,
// psr_d held for the whole cycle, done pulses once the low half has finished.
module pwm_scan_seq_psr_drive #(
  parameter int PSR_HALF = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic first,
  output logic psr_c,
  output logic psr_d,
  output logic done
);

  localparam int HW = (PSR_HALF > 1) ? $clog2(PSR_HALF) : 1;

  logic          busy_reg;
  logic [HW-1:0] half_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_reg     <= 1'b0;
      half_cnt_reg <= '0;
      psr_c        <= 1'b0;
      psr_d        <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy_reg     <= 1'b1;
        half_cnt_reg <= '0;
        psr_c        <= 1'b1;
        psr_d        <= first;
      end else if (busy_reg) begin
        if (half_cnt_reg == HW'(PSR_HALF - 1)) begin
          half_cnt_reg <= '0;
          if (psr_c) begin
            psr_c <= 1'b0;
          end else begin
            busy_reg <= 1'b0;
            psr_d    <= 1'b0;
            done     <= 1'b1;
          end
        end else begin
          half_cnt_reg <= half_cnt_reg + HW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pwm_scan_seq.sv
// LED-cube scan scheduler: walks planes and PWM levels, paces datapath loads/latches and
// lands buffer swaps on frame boundaries. PLANE_BLANK_EN selects the long inter-plane blank.
module pwm_scan_seq
  import pwm_scan_seq_pkg::*;
#(
  parameter int NPLANES   = DEF_NPLANES,
  parameter int NLEVELS   = DEF_NLEVELS,
  parameter int LVW       = $clog2(NLEVELS),
  parameter int PW        = $clog2(NPLANES),
  parameter int DWELL     = DEF_DWELL,
  parameter int PSR_HALF  = DEF_PSR_HALF,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enable,
  input  logic           swap_req,
  output logic           swap_ack,
  output logic           buf_sel,
  output logic [PW-1:0]  plane,
  output logic [LVW-1:0] level,
  output logic           load_start,
  input  logic           load_done,
  output logic           latch_strobe,
  output logic           psr_c,
  output logic           psr_d,
  output logic           col_enable,
  output logic           frame_tick
);

  localparam int DWW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BLANK_LEN = blank_len(BLANK_CYC);
  localparam int BW        = (BLANK_LEN > 1) ? $clog2(BLANK_LEN) : 1;
  localparam logic [LVW-1:0] LAST_LEVEL = LVW'(NLEVELS - 2);
  localparam logic [PW-1:0]  LAST_PLANE = PW'(NPLANES - 1);

  scan_state_t    state_reg;
  logic [DWW-1:0] dwell_cnt_reg;
  logic [BW-1:0]  blank_cnt_reg;
  logic           pend_reg;
  logic           psr_start_reg;
  logic           psr_done;
  logic [LVW-1:0] level_inc;
  logic           dwell_expired;
  logic           blank_last;
  logic           on_exit;

  assign level_inc     = level + LVW'(1);
  assign dwell_expired = (dwell_cnt_reg == DWW'(DWELL - 1));
  assign blank_last    = (blank_cnt_reg == BW'(BLANK_LEN - 1));
  // The level's dwell may be stretched until the overlapping pre-load reports done.
  assign on_exit       = dwell_expired && (!pend_reg || load_done);

  pwm_scan_seq_psr_drive #(
    .PSR_HALF(PSR_HALF)
  ) u_psr_drive (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (psr_start_reg),
    .first  (plane == '0),
    .psr_c  (psr_c),
    .psr_d  (psr_d),
    .done   (psr_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      plane         <= '0;
      level         <= '0;
      buf_sel       <= 1'b0;
      swap_ack      <= 1'b0;
      frame_tick    <= 1'b0;
      load_start    <= 1'b0;
      latch_strobe  <= 1'b0;
      col_enable    <= 1'b0;
      psr_start_reg <= 1'b0;
      pend_reg      <= 1'b0;
      dwell_cnt_reg <= '0;
      blank_cnt_reg <= '0;
    end else begin
      swap_ack      <= 1'b0;
      frame_tick    <= 1'b0;
      load_start    <= 1'b0;
      latch_strobe  <= 1'b0;
      psr_start_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (enable) begin
            state_reg     <= ST_BLANK;
            plane         <= '0;
            level         <= '0;
            blank_cnt_reg <= '0;
          end
        end
        ST_BLANK: begin
          if (blank_last) begin
            state_reg     <= ST_PSR;
            psr_start_reg <= 1'b1;
          end else begin
            blank_cnt_reg <= blank_cnt_reg + BW'(1);
          end
        end
        ST_PSR: begin
          if (psr_done) begin
            state_reg  <= ST_LOAD;
            load_start <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_done) begin
            state_reg    <= ST_LATCH;
            latch_strobe <= 1'b1;
            load_start   <= (level < LAST_LEVEL);
            pend_reg     <= (level < LAST_LEVEL);
          end
        end
        ST_LATCH: begin
          state_reg     <= ST_ON;
          col_enable    <= 1'b1;
          dwell_cnt_reg <= '0;
        end
        ST_ON: begin
          if (load_done) pend_reg <= 1'b0;
          if (!dwell_expired) dwell_cnt_reg <= dwell_cnt_reg + DWW'(1);
          if (on_exit) begin
            if (level != LAST_LEVEL) begin
              state_reg    <= ST_LATCH;
              level        <= level_inc;
              latch_strobe <= 1'b1;
              load_start   <= (level_inc < LAST_LEVEL);
              pend_reg     <= (level_inc < LAST_LEVEL);
            end else begin
              state_reg     <= enable ? ST_BLANK : ST_IDLE;
              col_enable    <= 1'b0;
              level         <= '0;
              blank_cnt_reg <= '0;
              if (plane == LAST_PLANE) begin
                plane      <= '0;
                frame_tick <= 1'b1;
                if (swap_req) begin
                  buf_sel  <= ~buf_sel;
                  swap_ack <= 1'b1;
                end
              end else begin
                plane <= plane + PW'(1);
              end
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_scan_seq.sv
// Self-checking bench for pwm_scan_seq with a scoreboard of expected latch and frame events.
// Expected plane gap follows PLANE_BLANK_EN when the bench is built with that macro.
module tb_pwm_scan_seq;

  localparam int NPL       = 5;
  localparam int NLEV      = 4;
  localparam int LVW       = 2;
  localparam int PW        = 3;
  localparam int DWELL     = 8;
  localparam int PSR_HALF  = 1;
  localparam int BLANK_CYC = 4;
  localparam int DP_DELAY  = 3;
  localparam int STRETCH   = 20;
`ifdef PLANE_BLANK_EN
  localparam int BL = BLANK_CYC;
`else
  localparam int BL = 1;
`endif
  // col_enable low between planes: blank, psr start, psr cycle, psr done, load wait, latch
  localparam int EXP_GAP = BL + 1 + 2 * PSR_HALF + 1 + (DP_DELAY + 1) + 1;

  typedef struct {
    int plane;
    int level;
    int on_len;
  } latch_exp_t;

  typedef struct {
    int buf_v;
    int ack;
  } frame_exp_t;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           enable;
  logic           swap_req;
  logic           swap_ack;
  logic           buf_sel;
  logic [PW-1:0]  plane;
  logic [LVW-1:0] level;
  logic           load_start;
  logic           load_done = 1'b0;
  logic           latch_strobe;
  logic           psr_c;
  logic           psr_d;
  logic           col_enable;
  logic           frame_tick;

  latch_exp_t exp_q[$];
  frame_exp_t frame_q[$];

  int check_cnt = 0;
  int err_cnt   = 0;
  int frame_cnt = 0;
  int ls_cnt    = 0;
  int dp_cnt    = 0;
  int run_cnt   = 0;
  int gap_cnt   = 0;
  int cur_on    = DWELL;
  int psr_rises = 0;
  int ls_snap;
  bit gap_active   = 1'b0;
  bit gap_chk_en   = 1'b1;
  bit stretch_armed = 1'b0;
  logic prev_col = 1'b0;
  logic prev_psr = 1'b0;
  logic prev_buf = 1'b0;

  pwm_scan_seq #(
    .NPLANES  (NPL),
    .NLEVELS  (NLEV),
    .LVW      (LVW),
    .PW       (PW),
    .DWELL    (DWELL),
    .PSR_HALF (PSR_HALF),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .buf_sel     (buf_sel),
    .plane       (plane),
    .level       (level),
    .load_start  (load_start),
    .load_done   (load_done),
    .latch_strobe(latch_strobe),
    .psr_c       (psr_c),
    .psr_d       (psr_d),
    .col_enable  (col_enable),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Datapath model: load_done DP_DELAY clocks after load_start; one armed load takes STRETCH.
  always @(negedge clk) begin
    load_done = 1'b0;
    if (!reset_n) begin
      dp_cnt = 0;
    end else begin
      if (dp_cnt > 0) begin
        dp_cnt--;
        if (dp_cnt == 0) load_done = 1'b1;
      end
      if (load_start) begin
        check_eq("dp_idle_at_load", 32'(dp_cnt), 32'd0);
        if (stretch_armed && latch_strobe && int'(plane) == 1 && int'(level) == 0) begin
          dp_cnt = STRETCH;
          stretch_armed = 1'b0;
        end else begin
          dp_cnt = DP_DELAY;
        end
      end
    end
  end

  // Monitor: pops scoreboard entries on latch_strobe / frame_tick, measures dwell and gaps.
  always @(negedge clk) begin
    latch_exp_t e;
    frame_exp_t f;
    if (!reset_n) begin
      exp_q.delete();
      run_cnt    = 0;
      gap_cnt    = 0;
      gap_active = 1'b0;
      cur_on     = DWELL;
      psr_rises  = 0;
    end else begin
      if (load_start) ls_cnt++;
      if (psr_c && !prev_psr) begin
        psr_rises++;
        check_eq("psr_d_rise", 32'(psr_d), 32'(plane == '0));
      end
      if (!psr_c && prev_psr) check_eq("psr_d_fall", 32'(psr_d), 32'(plane == '0));
      if (latch_strobe) begin
        if (col_enable) check_eq("on_len", 32'(run_cnt), 32'(cur_on));
        check_eq("latch_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          $display("latch plane %0d level %0d load_start %0b", plane, level, load_start);
          check_eq("latch_plane", 32'(plane), 32'(e.plane));
          check_eq("latch_level", 32'(level), 32'(e.level));
          check_eq("preload_start", 32'(load_start), 32'(e.level < NLEV - 2));
          if (e.level == 0) begin
            check_eq("psr_per_plane", 32'(psr_rises), 32'd1);
            psr_rises = 0;
          end
          cur_on = e.on_len;
        end
        run_cnt = 0;
      end else if (col_enable) begin
        run_cnt++;
      end
      if (!col_enable && prev_col) begin
        check_eq("on_len_last", 32'(run_cnt), 32'(cur_on));
        gap_active = gap_chk_en;
        gap_cnt    = 0;
      end
      if (!col_enable && gap_active) gap_cnt++;
      if (col_enable && !prev_col && gap_active) begin
        check_eq("plane_gap", 32'(gap_cnt), 32'(EXP_GAP));
        gap_active = 1'b0;
      end
      if (frame_tick) begin
        frame_cnt++;
        check_eq("frame_expected", 32'(frame_q.size() != 0), 32'd1);
        check_eq("frame_plane", 32'(plane), 32'd0);
        if (frame_q.size() != 0) begin
          f = frame_q.pop_front();
          $display("frame %0d buf_sel %0b swap_ack %0b", frame_cnt, buf_sel, swap_ack);
          check_eq("buf_sel", 32'(buf_sel), 32'(f.buf_v));
          check_eq("swap_ack", 32'(swap_ack), 32'(f.ack));
        end
      end
      if (swap_ack) check_eq("ack_on_tick", 32'(frame_tick), 32'd1);
      if (buf_sel != prev_buf) check_eq("buf_sel_on_tick", 32'(frame_tick), 32'd1);
    end
    prev_col = col_enable;
    prev_psr = psr_c;
    prev_buf = buf_sel;
  end

  // sel 0: frame count reached arg; 1: plane==arg; 2: latch of plane arg/16 level arg%16; 3: col off
  task automatic wait_until(input string tag, input int sel, input int arg, input int budget);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0:       hit = (frame_cnt >= arg);
        1:       hit = (int'(plane) == arg);
        2:       hit = latch_strobe && int'(plane) == arg / 16 && int'(level) == arg % 16;
        default: hit = !col_enable;
      endcase
    end
    check_eq(tag, 32'(hit), 32'd1);
  endtask

  task automatic push_plane(input int p, input int stretch_l0);
    for (int l = 0; l <= NLEV - 2; l++) begin
      exp_q.push_back('{p, l, (stretch_l0 != 0 && l == 0) ? STRETCH : DWELL});
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    swap_req = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_col_enable", 32'(col_enable), 32'd0);
    check_eq("rst_psr_c", 32'(psr_c), 32'd0);
    check_eq("rst_psr_d", 32'(psr_d), 32'd0);
    check_eq("rst_latch", 32'(latch_strobe), 32'd0);
    check_eq("rst_load_start", 32'(load_start), 32'd0);
    check_eq("rst_frame_tick", 32'(frame_tick), 32'd0);
    check_eq("rst_swap_ack", 32'(swap_ack), 32'd0);
    check_eq("rst_buf_sel", 32'(buf_sel), 32'd0);
    check_eq("rst_plane", 32'(plane), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Six frames worth of planes; the run stops after plane 2 of the sixth frame.
    for (int k = 0; k < 28; k++) push_plane(k % NPL, (k == 1) ? 1 : 0);
    frame_q.push_back('{0, 0});
    stretch_armed = 1'b1;
    enable = 1'b1;
    wait_until("wait_tick1", 0, 1, 2000);
    wait_until("wait_plane2_a", 1, 2, 500);
    swap_req = 1'b1;
    frame_q.push_back('{1, 1});
    frame_q.push_back('{0, 1});
    frame_q.push_back('{1, 1});
    wait_until("wait_tick4", 0, 4, 3000);
    wait_until("wait_plane2_b", 1, 2, 500);
    swap_req = 1'b0;
    frame_q.push_back('{1, 0});
    wait_until("wait_tick5", 0, 5, 2000);
    wait_until("wait_p2_l1", 2, 2 * 16 + 1, 500);
    enable     = 1'b0;
    gap_chk_en = 1'b0;
    wait_until("wait_col_off", 3, 0, 500);
    ls_snap = ls_cnt;
    repeat (150) @(negedge clk);
    check_eq("no_load_after_stop", 32'(ls_cnt), 32'(ls_snap));
    check_eq("stop_plane", 32'(plane), 32'd3);
    check_eq("stop_level", 32'(level), 32'd0);
    check_eq("stop_col_enable", 32'(col_enable), 32'd0);
    check_eq("latch_q_drained", 32'(exp_q.size()), 32'd0);
    check_eq("frame_q_drained", 32'(frame_q.size()), 32'd0);

    // Restart from IDLE begins at plane 0, then reset lands in the middle of an ON dwell.
    push_plane(0, 0);
    enable = 1'b1;
    wait_until("wait_p0_l1", 2, 1, 500);
    repeat (3) @(negedge clk);
    check_eq("pre_rst_col_enable", 32'(col_enable), 32'd1);
    check_eq("pre_rst_buf_sel", 32'(buf_sel), 32'd1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_col_enable", 32'(col_enable), 32'd0);
    check_eq("midrst_psr_c", 32'(psr_c), 32'd0);
    check_eq("midrst_latch", 32'(latch_strobe), 32'd0);
    check_eq("midrst_load_start", 32'(load_start), 32'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_rst_plane", 32'(plane), 32'd0);
    check_eq("post_rst_level", 32'(level), 32'd0);
    check_eq("post_rst_buf_sel", 32'(buf_sel), 32'd0);
    check_eq("post_rst_col_enable", 32'(col_enable), 32'd0);

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule
